// File: rtl/spi_shift_if.sv
// Parallel/serial bus of the SPI shift engine: host config, clock-generator strobes,
// serial lines and transfer status, grouped for the engine (slave) and its driver (master).
interface spi_shift_if #(
    parameter int unsigned P_MAX_CHAR = 32,
    parameter int unsigned P_LEN_BITS = 5
);
    logic                  i_go;
    logic [P_LEN_BITS-1:0] i_len;
    logic                  i_lsb_first;
    logic                  i_tx_negedge;
    logic                  i_rx_negedge;
    logic [P_MAX_CHAR-1:0] i_tx_data;
    logic                  i_pos_edge;
    logic                  i_neg_edge;
    logic                  i_miso;
    logic                  o_mosi;
    logic                  o_tip;
    logic                  o_last;
    logic                  o_done;
    logic [P_MAX_CHAR-1:0] o_rx_data;

    modport master (
        output i_go, i_len, i_lsb_first, i_tx_negedge, i_rx_negedge, i_tx_data,
               i_pos_edge, i_neg_edge, i_miso,
        input  o_mosi, o_tip, o_last, o_done, o_rx_data
    );

    modport slave (
        input  i_go, i_len, i_lsb_first, i_tx_negedge, i_rx_negedge, i_tx_data,
               i_pos_edge, i_neg_edge, i_miso,
        output o_mosi, o_tip, o_last, o_done, o_rx_data
    );
endinterface

// File: rtl/spi_shift.sv
// SPI data shift engine: serialises a latched transmit word onto MOSI and assembles MISO
// into a receive word, stepping on the clock generator's edge strobes.
module spi_shift #(
    parameter int unsigned P_MAX_CHAR = 32,
    parameter int unsigned P_LEN_BITS = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    spi_shift_if.slave bus
);
    // One extra counter bit so a full P_MAX_CHAR-bit character does not wrap.
    localparam int unsigned CW = P_LEN_BITS + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(P_MAX_CHAR);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state_q, state_d;

    logic [P_MAX_CHAR-1:0] tx_word_q;
    logic [P_MAX_CHAR-1:0] rx_word_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         kt_q;
    logic [CW-1:0]         kr_q;
    logic                  lsb_first_q;
    logic                  tx_neg_q;
    logic                  rx_neg_q;
    logic                  mosi_q;
    logic                  done_q;

    logic                  busy;
    logic                  go_ok;
    logic                  tx_fire;
    logic                  rx_fire;
    logic                  rx_final;
    logic [CW-1:0]         len_in;
    logic [CW-1:0]         len_m1;
    logic [P_LEN_BITS-1:0] tx_idx;
    logic [P_LEN_BITS-1:0] rx_idx;

    always_comb begin
        busy     = (state_q == ST_BUSY);
        go_ok    = !busy && bus.i_go;
        len_in   = (bus.i_len == '0) ? CNT_FULL : {1'b0, bus.i_len};
        len_m1   = len_q - CNT_ONE;
        tx_fire  = busy && (tx_neg_q ? bus.i_neg_edge : bus.i_pos_edge) && (kt_q < len_q);
        rx_fire  = busy && (rx_neg_q ? bus.i_neg_edge : bus.i_pos_edge) && (kr_q < len_q);
        rx_final = rx_fire && (kr_q == len_m1);
    end

    // Counters are below N whenever they are used as an index, so modular
    // arithmetic on the low bits gives N-1-k exactly.
    always_comb begin
        tx_idx = lsb_first_q ? kt_q[P_LEN_BITS-1:0]
                             : (len_m1[P_LEN_BITS-1:0] - kt_q[P_LEN_BITS-1:0]);
        rx_idx = lsb_first_q ? kr_q[P_LEN_BITS-1:0]
                             : (len_m1[P_LEN_BITS-1:0] - kr_q[P_LEN_BITS-1:0]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_go) state_d = ST_BUSY;
            ST_BUSY: if (rx_final) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_word_q   <= '0;
            rx_word_q   <= '0;
            len_q       <= '0;
            kt_q        <= '0;
            kr_q        <= '0;
            lsb_first_q <= 1'b0;
            tx_neg_q    <= 1'b0;
            rx_neg_q    <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= rx_final;
            if (go_ok) begin
                tx_word_q   <= bus.i_tx_data;
                len_q       <= len_in;
                lsb_first_q <= bus.i_lsb_first;
                tx_neg_q    <= bus.i_tx_negedge;
                rx_neg_q    <= bus.i_rx_negedge;
                kt_q        <= '0;
                kr_q        <= '0;
                rx_word_q   <= '0;
            end else begin
                if (tx_fire) begin
                    mosi_q <= tx_word_q[tx_idx];
                    kt_q   <= kt_q + CNT_ONE;
                end
                if (rx_fire) begin
                    rx_word_q[rx_idx] <= bus.i_miso;
                    kr_q              <= kr_q + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        bus.o_mosi    = mosi_q;
        bus.o_tip     = busy;
        bus.o_last    = busy && (kr_q == len_m1);
        bus.o_done    = done_q;
        bus.o_rx_data = rx_word_q;
    end
endmodule

// File: tb/tb_spi_shift.sv
// Bench for spi_shift: directed scenarios plus randomized transfers against a
// bit-sequence reference model of the serial transfer.
module tb_spi_shift;
    logic clk;
    logic rst;
    logic loop;
    logic miso_drv;

    int tests;
    int fails;

    logic        exp_mosi;
    logic [31:0] exp_rx;

    spi_shift_if #(.P_MAX_CHAR(32), .P_LEN_BITS(5)) bus ();

    spi_shift #(.P_MAX_CHAR(32), .P_LEN_BITS(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_miso = loop ? bus.o_mosi : miso_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic strobe(input logic on_neg);
        if (on_neg) bus.i_neg_edge = 1'b1;
        else        bus.i_pos_edge = 1'b1;
        tick();
        bus.i_neg_edge = 1'b0;
        bus.i_pos_edge = 1'b0;
    endtask

    // Model: the k-th launched bit is data[k] (LSB-first) or data[N-1-k]; the k-th
    // sampled bit lands in rx[k] or rx[N-1-k].
    task automatic do_xfer(input logic [4:0] len_f, input logic lsb, input logic txn,
                           input logic rxn, input logic [31:0] data, input logic [31:0] miso_pat,
                           input logic use_loop, input logic disturb, input string name);
        int unsigned n;
        logic [31:0] tx_seq;
        logic [31:0] rx_seq;
        n = (len_f == 5'd0) ? 32 : int'(len_f);
        tx_seq = '0;
        rx_seq = '0;
        exp_rx = '0;
        for (int unsigned k = 0; k < n; k++) begin
            tx_seq[k] = lsb ? data[k] : data[n-1-k];
            rx_seq[k] = use_loop ? tx_seq[k] : miso_pat[k];
            exp_rx[lsb ? k : n-1-k] = rx_seq[k];
        end

        bus.i_len        = len_f;
        bus.i_lsb_first  = lsb;
        bus.i_tx_negedge = txn;
        bus.i_rx_negedge = rxn;
        bus.i_tx_data    = data;
        bus.i_go         = 1'b1;
        loop             = use_loop && (txn != rxn);
        tick();
        bus.i_go = 1'b0;
        check({name, " tip_at_go"}, bus.o_tip, 1);
        check({name, " mosi_at_go"}, bus.o_mosi, exp_mosi);
        check({name, " rx_clear_at_go"}, bus.o_rx_data, 0);

        for (int unsigned k = 0; k < n; k++) begin
            if (!loop) miso_drv = rx_seq[k];
            if (txn != rxn) begin
                gap();
                strobe(txn);
                exp_mosi = tx_seq[k];
                check($sformatf("%s mosi[%0d]", name, k), bus.o_mosi, exp_mosi);
                if (disturb && k == n / 2) begin
                    bus.i_go         = 1'b1;
                    bus.i_tx_data    = ~data;
                    bus.i_len        = len_f + 5'd3;
                    bus.i_lsb_first  = ~lsb;
                    bus.i_tx_negedge = ~txn;
                    bus.i_rx_negedge = ~rxn;
                    tick();
                    bus.i_go = 1'b0;
                    check({name, " tip_after_rego"}, bus.o_tip, 1);
                end
                gap();
                check($sformatf("%s last[%0d]", name, k), bus.o_last, (k == n - 1));
                strobe(rxn);
            end else begin
                gap();
                check($sformatf("%s last[%0d]", name, k), bus.o_last, (k == n - 1));
                strobe(txn);
                exp_mosi = tx_seq[k];
                check($sformatf("%s mosi[%0d]", name, k), bus.o_mosi, exp_mosi);
            end
            if (k < n - 1) check($sformatf("%s tip[%0d]", name, k), bus.o_tip, 1);
        end

        check({name, " done_pulse"}, bus.o_done, 1);
        check({name, " tip_end"}, bus.o_tip, 0);
        check({name, " last_end"}, bus.o_last, 0);
        check({name, " rx_data"}, bus.o_rx_data, exp_rx);
    endtask

    task automatic finish_idle(input string name);
        tick();
        check({name, " done_low"}, bus.o_done, 0);
        check({name, " rx_hold"}, bus.o_rx_data, exp_rx);
        check({name, " mosi_hold"}, bus.o_mosi, exp_mosi);
    endtask

    task automatic idle_strobes(input string name);
        repeat (4) begin
            strobe(1'b0);
            strobe(1'b1);
            strobe(1'b0);
        end
        check({name, " idle_tip"}, bus.o_tip, 0);
        check({name, " idle_done"}, bus.o_done, 0);
        check({name, " idle_last"}, bus.o_last, 0);
        check({name, " idle_mosi"}, bus.o_mosi, exp_mosi);
        check({name, " idle_rx"}, bus.o_rx_data, exp_rx);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        loop = 1'b0;
        miso_drv = 1'b0;
        bus.i_go = 1'b0;
        bus.i_len = '0;
        bus.i_lsb_first = 1'b0;
        bus.i_tx_negedge = 1'b0;
        bus.i_rx_negedge = 1'b0;
        bus.i_tx_data = '0;
        bus.i_pos_edge = 1'b0;
        bus.i_neg_edge = 1'b0;
        exp_mosi = 1'b0;
        exp_rx = '0;

        #12;
        check("reset mosi", bus.o_mosi, 0);
        check("reset tip", bus.o_tip, 0);
        check("reset last", bus.o_last, 0);
        check("reset done", bus.o_done, 0);
        check("reset rx", bus.o_rx_data, 0);
        tick();
        rst = 1'b0;
        tick();

        do_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 32'h0, 1'b1, 1'b0, "t1_msb8");
        check("t1 rx_const", bus.o_rx_data, 32'h0000_00A5);
        finish_idle("t1");

        do_xfer(5'd4, 1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0006, 1'b0, 1'b0, "t2_lsb4");
        check("t2 rx_const", bus.o_rx_data, 32'h0000_0006);
        finish_idle("t2");

        do_xfer(5'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'h0, 1'b1, 1'b0, "t3_len32");
        check("t3 rx_const", bus.o_rx_data, 32'h8000_0001);
        finish_idle("t3");

        do_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_0096, 32'h0, 1'b1, 1'b1, "t4_regos");
        check("t4 rx_const", bus.o_rx_data, 32'h0000_0096);
        finish_idle("t4");
        idle_strobes("t4");

        do_xfer(5'd8, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 32'h0, 1'b1, 1'b0, "t5_same_edge");
        check("t5 rx_const", bus.o_rx_data, 32'h0000_003C);
        // go issued while o_done is still high
        do_xfer(5'd6, 1'b1, 1'b0, 1'b1, 32'h0000_0029, 32'h0000_0015, 1'b0, 1'b0, "t5b_chain");
        finish_idle("t5b");

        bus.i_len = 5'd8;
        bus.i_lsb_first = 1'b0;
        bus.i_tx_negedge = 1'b1;
        bus.i_rx_negedge = 1'b0;
        bus.i_tx_data = 32'h0000_00F0;
        loop = 1'b1;
        bus.i_go = 1'b1;
        tick();
        bus.i_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            strobe(1'b1);
            strobe(1'b0);
        end
        check("t6 pre_rx", bus.o_rx_data, 32'h0000_00E0);
        check("t6 pre_mosi", bus.o_mosi, 1);
        check("t6 pre_tip", bus.o_tip, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6 rst_tip", bus.o_tip, 0);
        check("t6 rst_rx", bus.o_rx_data, 0);
        check("t6 rst_mosi", bus.o_mosi, 0);
        check("t6 rst_last", bus.o_last, 0);
        check("t6 rst_done", bus.o_done, 0);
        tick();
        rst = 1'b0;
        loop = 1'b0;
        exp_mosi = 1'b0;
        exp_rx = '0;
        tick();
        check("t6 post_done", bus.o_done, 0);
        check("t6 post_tip", bus.o_tip, 0);
        do_xfer(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_005A, 32'h0, 1'b1, 1'b0, "t6_after");
        check("t6 rx_const", bus.o_rx_data, 32'h0000_005A);
        finish_idle("t6");

        for (int i = 0; i < 10; i++) begin
            logic [4:0]  r_len;
            logic        r_lsb;
            logic        r_txn;
            logic        r_rxn;
            logic        r_loop;
            logic [31:0] r_data;
            logic [31:0] r_pat;
            r_len  = 5'($urandom_range(0, 31));
            r_lsb  = 1'($urandom_range(0, 1));
            r_txn  = 1'($urandom_range(0, 1));
            r_rxn  = 1'($urandom_range(0, 1));
            r_loop = 1'($urandom_range(0, 1));
            r_data = $urandom;
            r_pat  = $urandom;
            do_xfer(r_len, r_lsb, r_txn, r_rxn, r_data, r_pat, r_loop, 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) finish_idle($sformatf("rnd%0d", i));
        end
        finish_idle("rnd_end");
        idle_strobes("rnd_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_shift.md
# spi_shift

SPI data shift engine sitting directly downstream of the SPI clock generator: it consumes the generator's single-cycle positive/negative edge strobes to serialise a parallel transmit word onto MOSI and assemble MISO into a parallel receive word. It owns the bit count of a transfer and feeds back transfer-in-progress (generator enable) and last-bit (generator last-clock) indications. Character length, bit order and launch/sample edges are configurable per transfer.

## Interface
- P_MAX_CHAR, 32, maximum character length in bits; also data port width
- P_LEN_BITS, 5, width of length field; 2**P_LEN_BITS == P_MAX_CHAR
- i_clk  in  1  system clock; all logic on its rising edge
- i_rst  in  1  asynchronous active-high reset
- i_go  in  1  start request; honoured only while o_tip=0
- i_len  in  P_LEN_BITS  character length N; 0 encodes P_MAX_CHAR
- i_lsb_first  in  1  1: bit 0 first; 0: bit N-1 first
- i_tx_negedge  in  1  1: launch MOSI on i_neg_edge; 0: on i_pos_edge
- i_rx_negedge  in  1  1: sample MISO on i_neg_edge; 0: on i_pos_edge
- i_tx_data  in  P_MAX_CHAR  transmit word, captured at go
- i_pos_edge  in  1  SCLK rising-edge strobe from clock generator
- i_neg_edge  in  1  SCLK falling-edge strobe from clock generator
- i_miso  in  1  serial input (synchronised upstream)
- o_mosi  out  1  serial output
- o_tip  out  1  transfer in progress; drives clock generator enable
- o_last  out  1  final bit pending; drives clock generator last-clock input
- o_done  out  1  one-cycle pulse at transfer completion
- o_rx_data  out  P_MAX_CHAR  received word

## Operation
- States: IDLE (o_tip=0), BUSY (o_tip=1).
- IDLE, i_go=1: latch i_tx_data, N (i_len, 0→P_MAX_CHAR), i_lsb_first, i_tx_negedge, i_rx_negedge; load tx counter kt=0, rx counter kr=0; clear o_rx_data to 0; enter BUSY. Config inputs ignored thereafter until next go.
- BUSY, i_go ignored.
- Tx edge (selected strobe) with kt<N: o_mosi <= tx bit at index kt (LSB-first) or N-1-kt (MSB-first); kt++. Tx edges with kt==N ignored.
- Rx edge (selected strobe) with kr<N: o_rx_data[kr] (LSB-first) or o_rx_data[N-1-kr] (MSB-first) <= i_miso; kr++.
- Tx and rx edges in the same cycle both act.
- Rx edge making kr==N: return to IDLE next cycle, o_done=1 for that one cycle.
- o_last = o_tip && (kr == N-1); combinational from registers.
- o_rx_data bits at index ≥N remain 0; o_rx_data stable in IDLE until next accepted go.
- Counters are P_LEN_BITS+1 wide so N=P_MAX_CHAR does not wrap.
- Strobes arriving in IDLE have no effect.

## Timing
- Reset values: o_mosi=0, o_tip=0, o_last=0, o_done=0, o_rx_data=0, kt=kr=0.
- Reset mid-transfer: all state cleared immediately; no o_done.
- go accepted on cycle t → o_tip=1 from t+1; o_mosi unchanged until first tx strobe.
- Nth rx strobe at cycle t → o_rx_data holds final bit, o_tip=0 and o_done=1 at t+1; o_done=0 at t+2.
- go in same cycle o_done is high is accepted (IDLE already).
- o_mosi holds last launched bit after transfer until next tx strobe of a new transfer.
- No combinational path from any input to any output.

## Test plan
- N=8, MSB-first, tx on neg, rx on pos, i_tx_data=0xA5, i_miso looped to o_mosi, strobes alternating neg/pos → o_mosi sequence 1,0,1,0,0,1,0,1; o_rx_data=0x000000A5; o_done one cycle after 8th pos strobe; o_last high exactly between 7th and 8th rx strobe.
- N=4, LSB-first, i_tx_data=0x3 → o_mosi 1,1,0,0; i_miso driven 0,1,1,0 → o_rx_data=0x6.
- i_len=0, i_tx_data=0x80000001, MSB-first loopback → 32 bits shifted, o_rx_data=0x80000001, o_done after 32nd rx strobe, no counter wrap.
- i_go re-pulsed and i_tx_data/i_len changed mid-transfer → ignored; result matches original config; strobes in IDLE leave outputs unchanged.
- Tx and rx on same edge (both pos) → both act per strobe; N=8 0x3C loopback yields rx sampled of just-launched bit, o_rx_data=0x3C.
- i_rst asserted after 3 rx strobes → o_tip, o_rx_data, o_mosi, o_last go 0 asynchronously, no o_done; subsequent go with 0x5A completes normally.
